halt_ctrl: RTL and testbench
============================

HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter STEP_W, default 8: width of the single-step instruction counter.
REQ-002 clk  input  1  free-running core clock; this block runs on the ungated clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 halt_req  input  1  level; debug halt request.
REQ-005 resume_req  input  1  single-cycle pulse; leave halt.
REQ-006 step_req  input  1  single-cycle pulse; run step_cnt instructions, then re-halt.
REQ-007 step_cnt  input  STEP_W  instruction count for step_req; sampled with step_req.
REQ-008 ebreak  input  1  single-cycle pulse; EBREAK retired this cycle.
REQ-009 instr_done  input  1  single-cycle pulse; an instruction retired this cycle.
REQ-010 hlt  output  1  clock-gate enable to the core; 1 = core clock stopped.
REQ-011 halted  output  1  state == HALTED, registered on the rising edge.
REQ-012 cause  output  2  halt cause: 00 none, 01 debug, 10 ebreak, 11 step.
REQ-013 step_busy  output  1  state == STEP.

Function
REQ-014 The FSM SHALL have four states: RUN, PEND, HALTED, STEP, updated on the rising clk edge.
REQ-015 In RUN, ebreak SHALL cause a transition to HALTED with cause=10; ebreak SHALL win over a simultaneous halt_req.
REQ-016 In RUN, halt_req without ebreak SHALL cause a transition to PEND.
REQ-017 In PEND, instr_done SHALL cause a transition to HALTED with cause=01; if halt_req drops before instr_done, the FSM SHALL return to RUN.
REQ-018 In HALTED, resume_req with halt_req=0 SHALL cause a transition to RUN and clear cause to 00; resume_req SHALL be ignored while halt_req=1.
REQ-019 In HALTED, step_req with step_cnt!=0 SHALL load the counter with step_cnt and cause a transition to STEP; step_req with step_cnt==0 SHALL be ignored.
REQ-020 When resume_req and step_req arrive in the same cycle, resume_req SHALL win.
REQ-021 In STEP, each instr_done SHALL decrement the counter; instr_done while the counter==1 SHALL cause a transition to HALTED with cause=11 and the counter at 0.
REQ-022 In STEP, ebreak SHALL cause a transition to HALTED with cause=10 and clear the counter; halt_req SHALL be ignored in STEP.
REQ-023 hlt SHALL be a flop clocked on the falling clk edge, loaded with (state==HALTED), so it never changes while clk is high (glitch-free gating).
REQ-024 Latency: an event at rising edge N SHALL change hlt at the falling edge of cycle N; after resume, the first core edge SHALL be rising edge N+1.
REQ-025 cause SHALL hold its value while in HALTED.

Reset
REQ-026 On rst_n=0, the block SHALL asynchronously set state=RUN, hlt=0, halted=0, cause=00, step_busy=0, counter=0.
REQ-027 rst_n assertion while in PEND, STEP or HALTED SHALL abort the operation immediately with no pending request retained.
REQ-028 Reset release SHALL be synchronous to the rising edge by the upstream reset synchronizer; this block adds no synchronizer.

Configuration
REQ-029 Macro HALT_CTRL_STEP_EN defined: STEP state and counter SHALL be present, and REQ-019..REQ-022 apply.
REQ-030 Macro HALT_CTRL_STEP_EN undefined: no STEP state and no counter; step_req and step_cnt SHALL be ignored, step_busy tied 0, cause=11 never produced; ports SHALL be unchanged.

Structure
REQ-031 State encodings (2-bit) and cause codes SHALL live in shared package rv_ctrl_pkg.
REQ-032 The down-counter SHALL be sub-module step_counter (load, dec, is_one, zero), instantiated only under HALT_CTRL_STEP_EN.

Verification
REQ-033 Reset mid-HALTED: rst_n low -> hlt=0, halted=0, cause=00 without waiting for a clock edge.
REQ-034 Debug halt: halt_req=1 in RUN, instr_done 3 cycles later -> PEND for 3 cycles, then HALTED, cause=01, hlt rises at the next falling edge.
REQ-035 Resume: resume_req with halt_req=0 -> RUN, cause=00, hlt falls half a cycle later; resume_req with halt_req=1 -> remains HALTED.
REQ-036 Single step: step_req with step_cnt=3 -> STEP; after 3 instr_done pulses -> HALTED, cause=11; step_cnt=0 -> ignored.
REQ-037 Ebreak: ebreak in RUN together with halt_req -> HALTED, cause=10; ebreak in STEP with counter=2 -> HALTED, cause=10, counter=0.
REQ-038 Glitch check: assert that hlt never toggles while clk=1 across all scenarios; resume_req and step_req in the same cycle -> RUN.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared FSM state encodings and halt cause codes for the debug halt controller.
// Contents: ST_* 2-bit state encodings, CAUSE_* 2-bit halt cause codes.
package rv_ctrl_pkg;
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_DEBUG  = 2'b01;
    localparam logic [1:0] CAUSE_EBREAK = 2'b10;
    localparam logic [1:0] CAUSE_STEP   = 2'b11;
endpackage

// File: rtl/step_counter.sv
// step_counter: single-step instruction down-counter.
// Ports: clk, rst_n (async active-low), load/load_val (load wins over dec),
//        dec (decrement, saturates at 0), is_one (count == 1), zero (count == 0).
module step_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - 1'b1;
    end
    assign zero   = cnt == '0;
    assign is_one = cnt == W'(1);
endmodule

// File: rtl/halt_ctrl.sv
// halt_ctrl: debug halt / resume / single-step controller driving the core clock-gate enable.
// Ports: clk (ungated), rst_n (async active-low), halt_req (level), resume_req, step_req,
//        step_cnt[STEP_W], ebreak, instr_done (pulses); hlt (gate enable, falling-edge flop),
//        halted, cause[2], step_busy.
// Build option: define HALT_CTRL_STEP_EN to include the STEP state and step_counter;
//               otherwise step_req/step_cnt are ignored and step_busy is tied 0.
module halt_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic              ebreak,
    input  logic              instr_done,
    output logic              hlt,
    output logic              halted,
    output logic [1:0]        cause,
    output logic              step_busy
);
    import rv_ctrl_pkg::*;

    logic [1:0] state, state_nx, cause_nx;

`ifdef HALT_CTRL_STEP_EN
    logic              cnt_load, cnt_dec, cnt_is_one, cnt_zero;
    logic [STEP_W-1:0] cnt_val;

    step_counter #(.W(STEP_W)) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one),
        .zero     (cnt_zero)
    );
`else
    logic unused_step;
    assign unused_step = ^{step_req, step_cnt};
`endif

    always_comb begin
        state_nx = state;
        cause_nx = cause;
`ifdef HALT_CTRL_STEP_EN
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
`endif
        case (state)
            ST_RUN:
                if (ebreak) begin
                    state_nx = ST_HALTED;
                    cause_nx = CAUSE_EBREAK;
                end else if (halt_req)
                    state_nx = ST_PEND;
            ST_PEND:
                if (instr_done) begin
                    state_nx = ST_HALTED;
                    cause_nx = CAUSE_DEBUG;
                end else if (!halt_req)
                    state_nx = ST_RUN;
            ST_HALTED:
                // a valid resume takes priority over a step request in the same cycle
                if (resume_req && !halt_req) begin
                    state_nx = ST_RUN;
                    cause_nx = CAUSE_NONE;
                end
`ifdef HALT_CTRL_STEP_EN
                else if (step_req && step_cnt != '0) begin
                    state_nx = ST_STEP;
                    cnt_load = 1'b1;
                    cnt_val  = step_cnt;
                end
            ST_STEP:
                // halt_req is deliberately not looked at while stepping
                if (ebreak) begin
                    state_nx = ST_HALTED;
                    cause_nx = CAUSE_EBREAK;
                    cnt_load = 1'b1;
                end else if (instr_done) begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one || cnt_zero) begin
                        state_nx = ST_HALTED;
                        cause_nx = CAUSE_STEP;
                    end
                end
`endif
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cause <= CAUSE_NONE;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
        end
    end

    // falling-edge flop: the gate enable only changes while clk is low
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            hlt <= 1'b0;
        else
            hlt <= state == ST_HALTED;
    end

    assign halted = state == ST_HALTED;
`ifdef HALT_CTRL_STEP_EN
    assign step_busy = state == ST_STEP;
`else
    assign step_busy = 1'b0;
`endif
endmodule

// File: tb/tb_halt_ctrl.sv
// tb_halt_ctrl: directed self-checking bench for halt_ctrl (expectations follow HALT_CTRL_STEP_EN).
module tb_halt_ctrl;
`ifdef HALT_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
    logic [7:0] step_cnt = 8'd0;
    logic       ebreak = 1'b0, instr_done = 1'b0;
    logic       hlt, halted, step_busy;
    logic [1:0] cause;
    int         errors = 0, checks = 0;

    halt_ctrl #(.STEP_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .step_req   (step_req),
        .step_cnt   (step_cnt),
        .ebreak     (ebreak),
        .instr_done (instr_done),
        .hlt        (hlt),
        .halted     (halted),
        .cause      (cause),
        .step_busy  (step_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // the gate enable must only move while clk is low (reset excepted)
    always @(hlt) if (rst_n === 1'b1) chk("hlt_clk_low", int'(clk), 0);

    initial begin
        #1 rst_n = 1'b0;
        #11;
        chk("rst_hlt", int'(hlt), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_cause", int'(cause), 0);
        chk("rst_busy", int'(step_busy), 0);
        tick();
        rst_n = 1'b1;

        // debug halt: PEND for 3 cycles, then HALTED on instr_done
        halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pend_halted", int'(halted), 0);
        end
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        chk("dbg_halted", int'(halted), 1);
        chk("dbg_cause", int'(cause), 1);
        chk("dbg_hlt_before_fall", int'(hlt), 0);
        @(negedge clk); #1;
        chk("dbg_hlt_after_fall", int'(hlt), 1);

        // resume ignored while halt_req is high, then taken
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("resume_blocked_halted", int'(halted), 1);
        chk("resume_blocked_cause", int'(cause), 1);
        halt_req = 1'b0;
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("resume_halted", int'(halted), 0);
        chk("resume_cause", int'(cause), 0);
        chk("resume_hlt_before_fall", int'(hlt), 1);
        @(negedge clk); #1;
        chk("resume_hlt_after_fall", int'(hlt), 0);

        // halt_req dropped in PEND returns to RUN; a later instr_done must not halt
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        chk("pend_abort_halted", int'(halted), 0);

        // ebreak beats halt_req in RUN; cause holds while halted
        ebreak = 1'b1;
        halt_req = 1'b1;
        tick();
        ebreak = 1'b0;
        halt_req = 1'b0;
        chk("ebrk_halted", int'(halted), 1);
        chk("ebrk_cause", int'(cause), 2);
        tick();
        tick();
        chk("ebrk_cause_hold", int'(cause), 2);

        // step with count 0 is ignored; count 3 steps three instructions
        step_req = 1'b1;
        step_cnt = 8'd0;
        tick();
        step_req = 1'b0;
        chk("step0_halted", int'(halted), 1);
        chk("step0_busy", int'(step_busy), 0);
        step_req = 1'b1;
        step_cnt = 8'd3;
        tick();
        step_req = 1'b0;
        chk("step_busy", int'(step_busy), int'(STEP_EN));
        chk("step_halted", int'(halted), int'(!STEP_EN));
        for (int i = 0; i < 3; i++) begin
            instr_done = 1'b1;
            tick();
            instr_done = 1'b0;
            chk("step_loop_busy", int'(step_busy), int'(STEP_EN && i < 2));
            chk("step_loop_halted", int'(halted), int'(!STEP_EN || i == 2));
            tick();
        end
        chk("step_cause", int'(cause), STEP_EN ? 3 : 2);
`ifdef HALT_CTRL_STEP_EN
        chk("step_cnt_end", int'(dut.u_step.cnt), 0);
`endif
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("resume2_halted", int'(halted), 0);

        // ebreak during STEP with two instructions left; halt_req ignored in STEP
        halt_req = 1'b1;
        tick();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        halt_req = 1'b0;
        chk("dbg2_cause", int'(cause), 1);
        step_req = 1'b1;
        step_cnt = 8'd3;
        tick();
        step_req = 1'b0;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        halt_req = 1'b1;
        tick();
        chk("step_ignores_halt", int'(step_busy), int'(STEP_EN));
`ifdef HALT_CTRL_STEP_EN
        chk("step_cnt_two", int'(dut.u_step.cnt), 2);
`endif
        halt_req = 1'b0;
        ebreak = 1'b1;
        tick();
        ebreak = 1'b0;
        chk("step_ebrk_halted", int'(halted), 1);
        chk("step_ebrk_cause", int'(cause), STEP_EN ? 2 : 1);
        chk("step_ebrk_busy", int'(step_busy), 0);
`ifdef HALT_CTRL_STEP_EN
        chk("step_ebrk_cnt", int'(dut.u_step.cnt), 0);
`endif

        // resume and step together: resume wins
        resume_req = 1'b1;
        step_req = 1'b1;
        step_cnt = 8'd5;
        tick();
        resume_req = 1'b0;
        step_req = 1'b0;
        chk("both_halted", int'(halted), 0);
        chk("both_busy", int'(step_busy), 0);
        chk("both_cause", int'(cause), 0);

        // reset during PEND drops the request
        halt_req = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_pend_halted", int'(halted), 0);
        halt_req = 1'b0;
        tick();
        rst_n = 1'b1;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        chk("rst_pend_no_halt", int'(halted), 0);

        // reset mid-HALTED clears outputs without a clock edge (clk high here)
        ebreak = 1'b1;
        tick();
        ebreak = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_hlt", int'(hlt), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hlt", int'(hlt), 0);
        chk("async_rst_halted", int'(halted), 0);
        chk("async_rst_cause", int'(cause), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_halted", int'(halted), 0);
        @(negedge clk); #1;
        chk("post_rst_hlt", int'(hlt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
